// File: rtl/jk_driver.sv
// Excitation sequencer that drives a bank of WIDTH JK flops to a requested target state.
// Define JK_TOGGLE_EN to emit toggle excitation (j=k=1) instead of set/reset excitation.
module jk_driver #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] mis_q, mis_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] exc_j, exc_k;
    logic [CW-1:0]    cnt_inc;
    logic             accept;

    assign accept  = tgt_valid && (state_q == S_IDLE);
    assign cnt_inc = cnt_q + CW'(1);

`ifdef JK_TOGGLE_EN
    assign exc_j = q_fb ^ tgt_data;
    assign exc_k = q_fb ^ tgt_data;
`else
    assign exc_j = ~q_fb & tgt_data;
    assign exc_k = q_fb & ~tgt_data;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = '0;
        k_d     = '0;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tgt_d   = tgt_data;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    err_d   = 1'b0;
                    mis_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: state_d = S_CHECK;
            S_CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    mis_d   = q_fb ^ tgt_q;
                    cnt_d   = cnt_inc;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            mis_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tgt_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mismatch  = mis_q;

endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: JK bank model in the loop, transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_jk_driver;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tgt_valid = 1'b0;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data = '0;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j, k;
    logic             busy, done, err;
    logic [WIDTH-1:0] mismatch;

    jk_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // JK register bank, with a preload port and a stuck-feedback override.
    logic [WIDTH-1:0] bank_q = '0;
    logic             load_en = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             stuck = 1'b0;
    logic [WIDTH-1:0] stuck_val = '0;

    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else         bank_q <= (j & ~bank_q) | (~k & bank_q);
    end
    assign q_fb = stuck ? stuck_val : bank_q;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since acceptance (0 = idle, 1 = drive cycle,
    // n >= 2 = the (n-1)-th check cycle).
    int               m_age;
    logic [WIDTH-1:0] m_tgt, m_j, m_k, m_mis;
    logic             m_done, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = 0; m_tgt = '0; m_j = '0; m_k = '0; m_mis = '0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_age == 0) begin
                if (tgt_valid) begin
                    m_age = 1;
                    m_tgt = tgt_data;
                    m_err = 1'b0;
                    m_mis = '0;
                    for (int b = 0; b < WIDTH; b++) begin
                        m_j[b] = 1'b0;
                        m_k[b] = 1'b0;
                        if (q_fb[b] != tgt_data[b]) begin
`ifdef JK_TOGGLE_EN
                            m_j[b] = 1'b1;
                            m_k[b] = 1'b1;
`else
                            if (tgt_data[b]) m_j[b] = 1'b1;
                            else             m_k[b] = 1'b1;
`endif
                        end
                    end
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (q_fb == m_tgt) begin
                m_done = 1'b1;
                m_age  = 0;
            end else if (m_age - 1 == TIMEOUT) begin
                m_err = 1'b1;
                m_mis = q_fb ^ m_tgt;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready",    32'(tgt_ready), 32'(m_age == 0));
            check("busy",     32'(busy),      32'(m_age != 0));
            check("j",        32'(j),         32'((m_age == 1) ? m_j : '0));
            check("k",        32'(k),         32'((m_age == 1) ? m_k : '0));
            check("done",     32'(done),      32'(m_done));
            check("err",      32'(err),       32'(m_err));
            check("mismatch", 32'(mismatch),  32'(m_mis));
            check("done_err_excl", 32'(done & err), 32'(0));
        end
    end

    task automatic wait_ready;
        int n = 0;
        @(negedge clk);
        while (!tgt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tgt_ready) check("ready_timeout", 32'(tgt_ready), 32'(1));
    endtask

    // Offers one target and returns 1 time unit after the accept edge.
    task automatic send(input logic [WIDTH-1:0] d);
        wait_ready();
        #1 tgt_valid = 1'b1;
        tgt_data = d;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        tgt_data = 4'hF;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        @(negedge clk);
        #1 load_en = 1'b1;
        load_val = v;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    logic [WIDTH-1:0] hs_tbl [9] = '{4'h3, 4'hC, 4'h7, 4'h1, 4'hE, 4'h9, 4'h6, 4'h0, 4'hB};
    int               n_acc;

    initial begin
        #12;
        check("rst_ready", 32'(tgt_ready), 32'(1));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_j",     32'(j),         32'(0));
        check("rst_k",     32'(k),         32'(0));
        check("rst_err",   32'(err),       32'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Set/reset (or toggle) excitation: 0101 -> 0011.
        load(4'b0101);
        send(4'b0011);
        @(negedge clk);
`ifdef JK_TOGGLE_EN
        check("t1_j", 32'(j), 32'(4'b0110));
        check("t1_k", 32'(k), 32'(4'b0110));
`else
        check("t1_j", 32'(j), 32'(4'b0010));
        check("t1_k", 32'(k), 32'(4'b0100));
`endif
        @(negedge clk);
        check("t1_q_after_e1", 32'(q_fb), 32'(4'b0011));
        check("t1_j_check",    32'(j),    32'(0));
        @(negedge clk);
        check("t1_done",  32'(done),      32'(1));
        check("t1_ready", 32'(tgt_ready), 32'(1));

        // Target equal to current state.
        load(4'b1010);
        send(4'b1010);
        @(negedge clk);
        check("t2_j", 32'(j), 32'(0));
        check("t2_k", 32'(k), 32'(0));
        @(negedge clk);
        @(negedge clk);
        check("t2_done", 32'(done), 32'(1));
        check("t2_err",  32'(err),  32'(0));

        // Timeout with feedback stuck at 0000.
        wait_ready();
        stuck = 1'b1;
        stuck_val = 4'b0000;
        send(4'b1001);
        repeat (4) @(negedge clk);
        check("t3_err_before", 32'(err), 32'(0));
        @(negedge clk);
        check("t3_err",      32'(err),      32'(1));
        check("t3_mismatch", 32'(mismatch), 32'(4'b1001));
        check("t3_no_done",  32'(done),     32'(0));
        check("t3_ready",    32'(tgt_ready), 32'(1));
        repeat (3) @(negedge clk);
        check("t3_err_sticky", 32'(err), 32'(1));
        stuck = 1'b0;
        send(4'b0110);
        @(negedge clk);
        check("t3_err_clr", 32'(err),      32'(0));
        check("t3_mis_clr", 32'(mismatch), 32'(0));

        // Valid held high with new data every cycle.
        wait_ready();
        n_acc = 0;
        #1 tgt_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tgt_data = hs_tbl[i];
            @(posedge clk);
            if (tgt_ready) n_acc++;
            #1;
        end
        tgt_valid = 1'b0;
        check("t4_accepts", 32'(n_acc), 32'(3));

        // Reset in the drive cycle.
        wait_ready();
        load(4'b0000);
        send(4'b1111);
        #1 rst_n = 1'b0;
        #1;
        check("t5_j",     32'(j),         32'(0));
        check("t5_k",     32'(k),         32'(0));
        check("t5_busy",  32'(busy),      32'(0));
        check("t5_ready", 32'(tgt_ready), 32'(1));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset in a check cycle.
        stuck = 1'b1;
        stuck_val = 4'b0000;
        send(4'b0101);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_ready", 32'(tgt_ready), 32'(1));
        check("t6_busy",  32'(busy),      32'(0));
        check("t6_j",     32'(j),         32'(0));
        check("t6_k",     32'(k),         32'(0));
        check("t6_done",  32'(done),      32'(0));
        check("t6_err",   32'(err),       32'(0));
        check("t6_mis",   32'(mismatch),  32'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        stuck = 1'b0;

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_driver.md
# jk_driver

Excitation sequencer that drives a bank of WIDTH JK flip-flops to a requested target state. It accepts a target word over a valid/ready handshake, computes per-bit J/K excitation from the bank's current Q and the target, and drives it for one clock. It then checks the bank's Q feedback and reports completion or a timeout error. It sits upstream of the JK register bank as its initiator: its `j`/`k` outputs feed the flops' `j`/`k` inputs, and the flops' `q` returns on `q_fb`.

## Interface
- WIDTH, 4, number of JK flops driven (>=1)
- TIMEOUT, 3, CHECK cycles allowed for `q_fb` to match before error (>=1)

- clk  input  1  rising-edge clock, shared with the JK bank
- rst_n  input  1  asynchronous, active-low reset
- tgt_valid  input  1  target word offered
- tgt_ready  output  1  block can accept a target (high only in IDLE)
- tgt_data  input  WIDTH  requested next state of the bank
- q_fb  input  WIDTH  current Q of the JK bank
- j  output  WIDTH  J excitation, registered
- k  output  WIDTH  K excitation, registered
- busy  output  1  high in DRIVE or CHECK
- done  output  1  one-cycle pulse: bank reached target
- err  output  1  sticky timeout flag; cleared on next accepted target
- mismatch  output  WIDTH  `q_fb ^ target` latched at timeout; cleared on next accept

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE: `tgt_ready`=1. On `tgt_valid & tgt_ready`:
  - latch `tgt_data` into `tgt_reg`;
  - compute j/k from the `q_fb` and `tgt_data` sampled at that edge;
  - clear `err` and `mismatch`, clear the timeout counter;
  - go to DRIVE.
- Excitation per bit i (current c=`q_fb[i]`, next n=`tgt_data[i]`):
  - c=n: j=0, k=0 (hold);
  - 0->1: j=1, k=0;
  - 1->0: j=0, k=1;
  - the toggle variant is under Configuration.
- DRIVE: lasts exactly one cycle with j/k valid. Go to CHECK; j/k return to 0 at that edge.
- CHECK: j=k=0.
  - If `q_fb == tgt_reg`: pulse `done` in the next cycle and go to IDLE.
  - Otherwise increment the counter. At the edge ending the TIMEOUT-th mismatching CHECK cycle: set `err`, latch `mismatch = q_fb ^ tgt_reg`, go to IDLE (no `done`).
- `tgt_valid` outside IDLE is ignored; `tgt_data` need not be held after acceptance.
- A target equal to the current state still runs DRIVE/CHECK with all-zero j/k and completes with `done`.
- Timeout counter width is $clog2(TIMEOUT+1); it does not wrap.

## Timing
- Reset (async, immediate):
  - state IDLE, `tgt_ready`=1;
  - j=k=0, so the bank holds;
  - `busy`=0, `done`=0, `err`=0, `mismatch`=0, `tgt_reg`=0, counter=0.
- Reset mid-DRIVE or mid-CHECK: j/k drop to 0 asynchronously. The bank may or may not have taken the excitation; no `done`/`err` is produced.
- Let E0 be the accept edge:
  - j/k valid E0..E1; the bank updates at E1;
  - CHECK E1..E2; on a match, `done`=1 for E2..E3 and `tgt_ready`=1 from E2;
  - a new target may be accepted at E3.
- `busy` tracks state exactly; `tgt_ready` = !`busy`.
- Timeout: `err` rises at edge E1+TIMEOUT and stays high until the next accept edge.
- `done` and `err` are never high in the same cycle.

## Configuration
- JK_TOGGLE_EN defined: bits that change are driven j=1, k=1 (toggle); unchanged bits j=0, k=0.
- JK_TOGGLE_EN undefined: set/reset excitation as in Operation; j=k=1 is never emitted.
- Handshake, FSM and timing are identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 mid-CHECK -> outputs immediately at reset values; `tgt_ready`=1, j=k=0.
- Set/reset excitation (macro off), WIDTH=4: `q_fb`=0101, target 0011, bank model connected -> j=0010, k=0100 for one cycle; `q_fb`=0011 after E1; `done` pulse at E2.
- Toggle build: same stimulus -> j=k=0110 for one cycle; same `done` timing.
- No-change target: `q_fb`=1010, target 1010 -> j=k=0000, `done` at E2, `err`=0.
- Timeout, TIMEOUT=3: bank model stuck at 0000, target 1001 -> no `done`; `err`=1 at E4; `mismatch`=1001; next accept clears both.
- Handshake: `tgt_valid` held high continuously with new data each cycle -> accepts only in IDLE. Back-to-back targets complete every 3 cycles; data offered while busy is dropped.
